// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared decode constants, FSM states and MIPS field-extraction helpers
// for the five-stage pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  // R-type shifts (sll/srl/sra) have func[5:2] == 0 and take no rs operand
  localparam logic [3:0] FUNC_SHIFT_HI = 4'b0000;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] idx;
  } reg_ref_t;

  function automatic logic [5:0] opcode_of(input logic [31:0] inst);
    return inst[31:26];
  endfunction

  function automatic reg_ref_t dest_of(input logic [31:0] inst);
    reg_ref_t r;
    r.valid = 1'b0;
    r.idx   = inst[20:16];
    case (inst[31:26])
      OP_RTYPE: begin
        r.valid = 1'b1;
        r.idx   = inst[15:11];
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_LW: r.valid = 1'b1;
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

  function automatic reg_ref_t src_rs_of(input logic [31:0] inst);
    reg_ref_t r;
    r.idx = inst[25:21];
    case (inst[31:26])
      OP_RTYPE: r.valid = (inst[5:2] != FUNC_SHIFT_HI);
      OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI: r.valid = 1'b1;
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

  function automatic reg_ref_t src_rt_of(input logic [31:0] inst);
    reg_ref_t r;
    r.idx = inst[20:16];
    case (inst[31:26])
      OP_RTYPE, OP_SW, OP_BEQ: r.valid = 1'b1;
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bus between the pipeline datapath (master) and the hazard controller (slave):
// stage instructions and debug inputs in, register enables/flushes and counters out.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [31:0]      PR_IFID_Inst;
    logic [31:0]      PR_IDEX_Inst;
    logic [31:0]      PR_EXMEM_Inst;
    logic             branch_taken;
    logic             run_mode;
    logic             step_pulse;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             pipe_advance;
    logic             halted;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output PR_IFID_Inst, PR_IDEX_Inst, PR_EXMEM_Inst,
        output branch_taken, run_mode, step_pulse,
        input  pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush,
        input  pipe_advance, halted, stall_count, flush_count
    );

    modport slave (
        input  PR_IFID_Inst, PR_IDEX_Inst, PR_EXMEM_Inst,
        input  branch_taken, run_mode, step_pulse,
        output pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush,
        output pipe_advance, halted, stall_count, flush_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_decode.sv
// Combinational RAW detector: ID-stage sources against the destinations of
// ID/EX and EX/MEM (write-first register file makes MEM/WB harmless).
module pipeline_hazard_ctrl_hazard_decode
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter bit HAZ_REG_ZERO = 1'b1
) (
    input  logic [31:0] i_id_inst,
    input  logic [31:0] i_ex_inst,
    input  logic [31:0] i_mem_inst,
    output logic        o_raw_hazard
);

    reg_ref_t w_rs;
    reg_ref_t w_rt;
    reg_ref_t w_ex_dst;
    reg_ref_t w_mem_dst;

    function automatic logic hits(input reg_ref_t src, input reg_ref_t dst);
        return src.valid && dst.valid && (src.idx == dst.idx) &&
               (!HAZ_REG_ZERO || (dst.idx != '0));
    endfunction

    always_comb begin
        w_rs         = src_rs_of(i_id_inst);
        w_rt         = src_rt_of(i_id_inst);
        w_ex_dst     = dest_of(i_ex_inst);
        w_mem_dst    = dest_of(i_mem_inst);
        o_raw_hazard = hits(w_rs, w_ex_dst)  || hits(w_rt, w_ex_dst) ||
                       hits(w_rs, w_mem_dst) || hits(w_rt, w_mem_dst);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: stall on RAW, flush on taken BEQ in MEM, halt/step debug
// FSM, and saturating stall/flush event counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W        = 16,
    parameter bit          HAZ_REG_ZERO = 1'b1
) (
    input logic                   clock,
    input logic                   reset,
    pipeline_hazard_ctrl_if.slave bus
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_raw_hazard;
    logic             w_flush_req;
    logic             w_active;

    pipeline_hazard_ctrl_hazard_decode #(
        .HAZ_REG_ZERO(HAZ_REG_ZERO)
    ) u_hazard_decode (
        .i_id_inst   (bus.PR_IFID_Inst),
        .i_ex_inst   (bus.PR_IDEX_Inst),
        .i_mem_inst  (bus.PR_EXMEM_Inst),
        .o_raw_hazard(w_raw_hazard)
    );

    assign w_flush_req = bus.branch_taken && (opcode_of(bus.PR_EXMEM_Inst) == OP_BEQ);
    assign w_active    = !reset && (r_state != ST_HALT);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:  if (!bus.run_mode) w_state_nxt = ST_HALT;
            ST_HALT: begin
                if (bus.run_mode)        w_state_nxt = ST_RUN;
                else if (bus.step_pulse) w_state_nxt = ST_STEP;
            end
            ST_STEP: w_state_nxt = bus.run_mode ? ST_RUN : ST_HALT;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // Reset forces every stage register to load a NOP; HALT freezes everything.
    always_comb begin
        bus.pc_write     = 1'b0;
        bus.ifid_write   = 1'b0;
        bus.ifid_flush   = 1'b0;
        bus.idex_flush   = 1'b0;
        bus.exmem_flush  = 1'b0;
        bus.pipe_advance = 1'b0;
        bus.halted       = !reset && (r_state == ST_HALT);
        if (reset) begin
            bus.ifid_flush  = 1'b1;
            bus.idex_flush  = 1'b1;
            bus.exmem_flush = 1'b1;
        end else if (w_active) begin
            bus.pipe_advance = 1'b1;
            if (w_flush_req) begin
                bus.pc_write    = 1'b1;
                bus.ifid_write  = 1'b1;
                bus.ifid_flush  = 1'b1;
                bus.idex_flush  = 1'b1;
                bus.exmem_flush = 1'b1;
            end else if (w_raw_hazard) begin
                bus.idex_flush = 1'b1;
            end else begin
                bus.pc_write   = 1'b1;
                bus.ifid_write = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (w_active) begin
            if (w_flush_req && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
            if (!w_flush_req && w_raw_hazard && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign bus.stall_count = r_stall_cnt;
    assign bus.flush_count = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: expected control/counter values are
// queued per driven cycle and compared against the DUT mid-cycle.
module tb_pipeline_hazard_ctrl;

    localparam logic [31:0] NOP   = 32'h0000_0000;
    localparam logic [31:0] LW2   = 32'h8C22_0000; // lw   $2,0($1)
    localparam logic [31:0] ADD   = 32'h0044_1820; // add  $3,$2,$4
    localparam logic [31:0] ADD7  = 32'h00A6_3820; // add  $7,$5,$6
    localparam logic [31:0] ADDI0 = 32'h2000_0005; // addi $0,$0,5
    localparam logic [31:0] ADD0  = 32'h0000_2020; // add  $4,$0,$0
    localparam logic [31:0] BEQ   = 32'h1000_0003; // beq  $0,$0,3
    localparam logic [31:0] SW2   = 32'hAC02_0000; // sw   $2,0($0)
    localparam logic [31:0] SLL   = 32'h0045_1880; // sll  $3,$5,2 with rs field = 2

    // {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_advance, halted}
    localparam logic [6:0] C_RUN   = 7'b1100010;
    localparam logic [6:0] C_STALL = 7'b0001010;
    localparam logic [6:0] C_FLUSH = 7'b1111110;
    localparam logic [6:0] C_HALT  = 7'b0000001;
    localparam logic [6:0] C_RST   = 7'b0011100;

    typedef struct packed {
        logic [6:0] ctl;
        logic [3:0] st;
        logic [3:0] fl;
    } exp_t;

    logic clock;
    logic reset;
    exp_t sb[$];
    int   n_pass;
    int   n_total;

    pipeline_hazard_ctrl_if #(.CNT_W(4)) bus ();

    pipeline_hazard_ctrl #(
        .CNT_W       (4),
        .HAZ_REG_ZERO(1'b1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_now();
        exp_t       e;
        logic [6:0] ctl;
        if (sb.size() == 0) begin
            n_total++;
            $error("FAIL scoreboard: observed empty queue, expected an entry");
            return;
        end
        e   = sb.pop_front();
        ctl = {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_flush,
               bus.exmem_flush, bus.pipe_advance, bus.halted};
        n_total++;
        assert (ctl === e.ctl) n_pass++;
        else $error("FAIL ctl @%0t: observed %b expected %b", $time, ctl, e.ctl);
        n_total++;
        assert (bus.stall_count === e.st) n_pass++;
        else $error("FAIL stall_count @%0t: observed %0d expected %0d", $time, bus.stall_count, e.st);
        n_total++;
        assert (bus.flush_count === e.fl) n_pass++;
        else $error("FAIL flush_count @%0t: observed %0d expected %0d", $time, bus.flush_count, e.fl);
    endtask

    task automatic cyc(input logic rst, input logic rm, input logic sp, input logic bt,
                       input logic [31:0] id, input logic [31:0] ex, input logic [31:0] mem,
                       input logic [6:0] ctl, input logic [3:0] st, input logic [3:0] fl);
        @(negedge clock);
        reset             = rst;
        bus.run_mode      = rm;
        bus.step_pulse    = sp;
        bus.branch_taken  = bt;
        bus.PR_IFID_Inst  = id;
        bus.PR_IDEX_Inst  = ex;
        bus.PR_EXMEM_Inst = mem;
        sb.push_back('{ctl: ctl, st: st, fl: fl});
        #2;
        check_now();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b1;
        bus.run_mode      = 1'b1;
        bus.step_pulse    = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.PR_IFID_Inst  = NOP;
        bus.PR_IDEX_Inst  = NOP;
        bus.PR_EXMEM_Inst = NOP;
        @(negedge clock);

        // reset, then load-use pair resolving over two stall cycles
        cyc(1, 1, 0, 0, NOP, NOP, NOP, C_RST,   0, 0);
        cyc(0, 1, 0, 0, NOP, NOP, NOP, C_RUN,   0, 0);
        cyc(0, 1, 0, 0, ADD, LW2, NOP, C_STALL, 0, 0);
        cyc(0, 1, 0, 0, ADD, NOP, LW2, C_STALL, 1, 0);
        cyc(0, 1, 0, 0, ADD, NOP, NOP, C_RUN,   2, 0);
        // $0 destination is never a hazard
        cyc(0, 1, 0, 0, ADD0, ADDI0, NOP,   C_RUN, 2, 0);
        cyc(0, 1, 0, 0, ADD0, NOP,   ADDI0, C_RUN, 2, 0);
        // one intervening instruction leaves a single stall
        cyc(0, 1, 0, 0, ADD, ADD7, LW2, C_STALL, 2, 0);
        // taken BEQ overrides a concurrent RAW
        cyc(0, 1, 0, 1, ADD, LW2, BEQ, C_FLUSH, 3, 0);
        // branch_taken without a BEQ in MEM is ignored
        cyc(0, 1, 0, 1, NOP, NOP, LW2, C_RUN, 3, 1);
        // SW has no destination; shifts do not read rs
        cyc(0, 1, 0, 0, ADD, SW2, NOP, C_RUN, 3, 1);
        cyc(0, 1, 0, 0, SLL, LW2, NOP, C_RUN, 3, 1);

        // halt: hazards and flush requests frozen out for 10 cycles
        cyc(0, 0, 0, 0, NOP, NOP, NOP, C_RUN, 3, 1);
        for (int i = 0; i < 10; i++)
            cyc(0, 0, 0, 1, ADD, LW2, BEQ, C_HALT, 3, 1);
        // single step: exactly one active cycle
        cyc(0, 0, 1, 0, NOP, NOP, NOP, C_HALT, 3, 1);
        cyc(0, 0, 0, 0, NOP, NOP, NOP, C_RUN,  3, 1);
        cyc(0, 0, 0, 0, NOP, NOP, NOP, C_HALT, 3, 1);
        // step into a hazard; step_pulse inside STEP is ignored
        cyc(0, 0, 1, 0, NOP, NOP, NOP, C_HALT,  3, 1);
        cyc(0, 0, 1, 0, ADD, LW2, NOP, C_STALL, 3, 1);
        cyc(0, 0, 0, 0, NOP, NOP, NOP, C_HALT,  4, 1);
        // resume; step_pulse in RUN is ignored
        cyc(0, 1, 0, 0, NOP, NOP, NOP, C_HALT, 4, 1);
        cyc(0, 1, 1, 0, NOP, NOP, NOP, C_RUN,  4, 1);
        cyc(0, 1, 0, 0, NOP, NOP, NOP, C_RUN,  4, 1);

        // stall counter saturates at 15
        for (int i = 0; i < 20; i++)
            cyc(0, 1, 0, 0, ADD, LW2, NOP, C_STALL, (4 + i > 15) ? 4'd15 : 4'(4 + i), 1);
        cyc(0, 1, 0, 0, ADD, LW2, NOP, C_STALL, 15, 1);

        // reset mid-stall
        cyc(1, 1, 0, 0, ADD, LW2, NOP, C_RST,   15, 1);
        cyc(0, 1, 0, 0, ADD, LW2, NOP, C_STALL, 0,  0);
        // reset mid-step returns to RUN even with run_mode low
        cyc(0, 0, 0, 0, NOP, NOP, NOP, C_RUN,  1, 0);
        cyc(0, 0, 1, 0, NOP, NOP, NOP, C_HALT, 1, 0);
        cyc(1, 0, 0, 0, NOP, NOP, NOP, C_RST,  1, 0);
        cyc(0, 0, 0, 0, NOP, NOP, NOP, C_RUN,  0, 0);
        cyc(0, 1, 0, 0, NOP, NOP, NOP, C_HALT, 0, 0);
        cyc(0, 1, 0, 0, NOP, NOP, NOP, C_RUN,  0, 0);

        @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
